// File: rtl/multi_edge_pulse_generator_if.sv
// Channel bundle for multi_edge_pulse_generator: monitored inputs, mode/clear controls,
// and the pulse and sticky-miss outputs.
interface multi_edge_pulse_generator_if #(
    parameter int N = 4
);
    logic [N-1:0]   x;
    logic [2*N-1:0] mode;
    logic [N-1:0]   clear_miss;
    logic [N-1:0]   z;
    logic [N-1:0]   miss;

    modport master (output x, mode, clear_miss, input z, miss);
    modport slave  (input x, mode, clear_miss, output z, miss);
endinterface

// File: rtl/multi_edge_pulse_generator.sv
// N-channel edge detector emitting W-cycle strobes, with retrigger-or-drop policy.
// Define PULSE_SYNC_EN to insert a two-flop synchroniser ahead of the sample stage.
module multi_edge_pulse_generator #(
    parameter int N      = 4,
    parameter int W      = 3,
    parameter bit RETRIG = 1'b0
) (
    input  logic clock,
    input  logic reset,
    multi_edge_pulse_generator_if.slave bus
);
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] RELOAD = CW'(W - 1);
`ifdef PULSE_SYNC_EN
    localparam int PRIME_LEN = 3;
`else
    localparam int PRIME_LEN = 1;
`endif

    typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} state_t;

    logic [N-1:0]         in_s;
    logic [N-1:0]         xs_r;
    logic [N-1:0]         xd_r;
    logic [N-1:0]         edge_s;
    logic [N-1:0]         miss_r;
    logic [N-1:0]         miss_s;
    logic [N-1:0]         z_s;
    logic [PRIME_LEN-1:0] prime_r;
    logic                 primed_s;
    state_t               state_r [N];
    state_t               state_s [N];
    logic [CW-1:0]        cnt_r   [N];
    logic [CW-1:0]        cnt_s   [N];

`ifdef PULSE_SYNC_EN
    logic [N-1:0] sync1_r;
    logic [N-1:0] sync2_r;

    // Two-flop synchroniser for asynchronous inputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= bus.x;
            sync2_r <= sync1_r;
        end
    end
    assign in_s = sync2_r;
`else
    assign in_s = bus.x;
`endif

    // Priming becomes valid once the sample stage holds a real input level
    assign primed_s = prime_r[PRIME_LEN-1];

    // Sample/delay pipeline; the delay stage mirrors the sample until primed so
    // levels present at reset release never look like edges
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            xs_r    <= '0;
            xd_r    <= '0;
            prime_r <= '0;
        end else begin
            xs_r    <= in_s;
            xd_r    <= primed_s ? xs_r : in_s;
            prime_r <= (prime_r << 1) | PRIME_LEN'(1);
        end
    end

    // Per-channel qualified edge detection
    always_comb begin
        edge_s = '0;
        for (int i = 0; i < N; i++) begin
            edge_s[i] = primed_s &
                        (((xs_r[i] & ~xd_r[i]) & bus.mode[2*i]) |
                         ((~xs_r[i] & xd_r[i]) & bus.mode[2*i+1]));
        end
    end

    // Per-channel next-state, counter and sticky-miss logic
    always_comb begin
        miss_s = '0;
        for (int i = 0; i < N; i++) begin
            state_s[i] = state_r[i];
            cnt_s[i]   = cnt_r[i];
            miss_s[i]  = miss_r[i] & ~bus.clear_miss[i];
            case (state_r[i])
                IDLE: begin
                    if (edge_s[i]) begin
                        state_s[i] = PULSE;
                        cnt_s[i]   = RELOAD;
                    end else begin
                        state_s[i] = IDLE;
                    end
                end
                PULSE: begin
                    if (edge_s[i] && RETRIG) begin
                        cnt_s[i] = RELOAD;
                    end else if (cnt_r[i] == '0) begin
                        state_s[i] = IDLE;
                    end else begin
                        cnt_s[i] = cnt_r[i] - CW'(1);
                    end
                    // set wins over a same-cycle clear
                    if (edge_s[i] && !RETRIG) begin
                        miss_s[i] = 1'b1;
                    end else begin
                        miss_s[i] = miss_s[i];
                    end
                end
                default: begin
                    state_s[i] = IDLE;
                    cnt_s[i]   = '0;
                end
            endcase
        end
    end

    // State, counter and miss registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miss_r <= '0;
            for (int i = 0; i < N; i++) begin
                state_r[i] <= IDLE;
                cnt_r[i]   <= '0;
            end
        end else begin
            miss_r <= miss_s;
            for (int i = 0; i < N; i++) begin
                state_r[i] <= state_s[i];
                cnt_r[i]   <= cnt_s[i];
            end
        end
    end

    // Pulse outputs decode directly from the state flops
    always_comb begin
        z_s = '0;
        for (int i = 0; i < N; i++) begin
            z_s[i] = (state_r[i] == PULSE);
        end
    end

    assign bus.z    = z_s;
    assign bus.miss = miss_r;
endmodule

// File: doc/multi_edge_pulse_generator.md
# multi_edge_pulse_generator

Parametrised, fully synchronous successor to the single-channel edge pulse generators: N independent channels, each detecting rising, falling or both edges of its input `x[i]` and emitting a clock-aligned pulse of W cycles on `z[i]`. Per-channel mode is selected at run time. Retrigger-or-drop policy is fixed at build time, and dropped edges are recorded in sticky flags. It sits between asynchronous or slow control inputs and synchronous consumers that need exactly-W-cycle strobes.

## Interface
- `N`, default 4: channel count, 1..32.
- `W`, default 3: pulse width in clock cycles, 1..65535; counter width is `$clog2(W+1)`.
- `RETRIG`, default 0: 1 = an edge during a pulse reloads the counter; 0 = the edge is dropped and flagged.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `x`  in  N  monitored inputs; may be asynchronous only when `PULSE_SYNC_EN` is defined.
- `mode`  in  2N  per-channel edge select `mode[2i+1:2i]`:
  - 00 = off
  - 01 = rising
  - 10 = falling
  - 11 = both
- `clear_miss`  in  N  synchronous per-channel clear of `miss`.
- `z`  out  N  registered pulse outputs.
- `miss`  out  N  sticky flag: an edge was dropped while `z[i]`=1 (RETRIG=0 only).

## Operation
- Per channel, registered stages:
  - sample register `xs[i]`, loaded from `x[i]` every cycle;
  - delayed register `xd[i]`, loaded from `xs[i]` every cycle;
  - down-counter `cnt[i]`;
  - `z[i]`, `miss[i]`.
- One shared `primed` bit, common to all channels.
- Edge detection:
  - rising = `xs & ~xd`;
  - falling = `~xs & xd`;
  - the detected edge is masked by `mode[i]`.
- `primed` handling:
  - `primed` is 0 out of reset.
  - On the first clock after reset release, `xd` is loaded from `x` directly (same value as `xs`), and `primed` is set to 1.
  - No edge is ever reported for levels present at reset release.
- Per-channel states:
  - IDLE (`z`=0): qualifying edge → PULSE with `cnt`=W-1 and `z`=1.
  - PULSE (`z`=1): `cnt`≠0 → `cnt`-1; `cnt`=0 → IDLE with `z`=0.
  - PULSE with a qualifying edge and RETRIG=1: `cnt` reloads to W-1 and `z` stays 1.
  - PULSE with a qualifying edge and RETRIG=0: edge ignored, `miss[i]` set to 1.
  - The PULSE edge rules apply in every PULSE cycle, including the final one (`cnt`=0).
- `miss[i]`:
  - cleared by `clear_miss[i]`=1;
  - if set and clear occur in the same cycle, set wins;
  - with RETRIG=1, `miss` is constant 0.
- `mode` changes take effect on the next detection. A pulse in progress always completes, even if the mode changes to 00.
- Channels are fully independent. No arbitration.

## Timing
- Reset values:
  - `z`=0, `miss`=0, `cnt`=0;
  - `xs`=0, `xd`=0, `primed`=0.
- Latency, with the clock edge k being the first edge to sample the new `x` level:
  - `z` rises after edge k+1;
  - `z` falls after edge k+1+W.
  - `z` is therefore high for exactly W cycles.
- W=1: single-cycle strobe, state machine never holds PULSE beyond one cycle.
- Retrigger extension: an edge detected in cycle j while `z`=1 makes the last high cycle j+W. No glitch low cycle.
- Back-to-back with RETRIG=0: the next edge must be detected at least one cycle after `z` falls to be serviced. Minimum input period is W+1 cycles per serviced edge.
- Mode 11: both transitions of an input pulse two cycles wide with W=1 yield two separate strobes.
- Reset asserted mid-pulse: `z` and `miss` drop asynchronously. After release, the priming rule applies.

## Configuration
- `PULSE_SYNC_EN` defined:
  - a two-flop synchroniser (reset to 0) is inserted ahead of `xs`;
  - latency grows by 2 cycles (`z` rises after edge k+3);
  - priming applies to the synchroniser output, so `primed` sets after 3 clocks;
  - `x` may be asynchronous.
- `PULSE_SYNC_EN` undefined:
  - no synchroniser;
  - `x` must be synchronous to `clock`;
  - latency as in Timing.

## Test plan
- Reset release with `x`=4'b1111, `mode`=all 11 → `z` stays 0 for 10 cycles, `miss`=0.
- N=4, W=3, ch0 mode 01, `x[0]` 0→1 sampled at edge k → `z[0]`=1 after edges k+1..k+3, 0 after k+4. Other channels stay 0.
- Same setup, ch1 mode 10, `x[1]` 1→0 then 0→1 → exactly one 3-cycle pulse, on the falling edge only.
- RETRIG=0, W=3, second rising edge 2 cycles after the first → `z` high 3 cycles total, `miss[0]`=1. `clear_miss[0]` pulse → `miss[0]`=0. Simultaneous new miss and clear → `miss`=1.
- RETRIG=1, W=3, second edge detected in the last high cycle j → `z` continuously high through j+3. `miss`=0.
- Reset asserted while `cnt`=1 → `z` 0 immediately. With `PULSE_SYNC_EN`, repeat the second scenario and check `z` rises after edge k+3.
